mul_acc: RTL and testbench
==========================

Name: mul_acc

Overview:
- Streaming multiply-accumulate stage placed directly around the 16x16 array multiplier `mul`.
- Accepts operand pairs over a valid/ready handshake and registers them into one `mul` instance.
- Sums the 16-bit (low-half, truncated) products of one vector, delimited by `in_last`.
- Presents the sum and the beat count on a valid/ready output port for downstream consumers.

Parameters:
- ACC_W, 32: accumulator and out_sum width; legal range 17..48.
- CNT_W, 16: beat-counter and out_count width.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair present.
- in_ready  output  1  block can accept a pair this cycle.
- in_a  input  16  multiplicand.
- in_b  input  16  multiplier.
- in_last  input  1  final pair of the current vector.
- out_valid  output  1  result held in output register.
- out_ready  input  1  downstream accepts result.
- out_sum  output  ACC_W  sum of truncated products.
- out_count  output  CNT_W  number of pairs in the vector.
- out_ovf  output  1  accumulator carried out of ACC_W bits at least once in the vector.

Behaviour:
- Reset state:
  - on rst=1 at a clock edge: s1_valid=0, acc=0, cnt=0, ovf=0, state=IDLE.
  - out_valid=0; out_sum, out_count and out_ovf all 0; in_ready=1 from the next cycle.
  - A vector in flight when rst is asserted is discarded, with no partial output.
- Input handshake:
  - A pair transfers on an edge where in_valid && in_ready.
  - in_ready = !s1_valid || s1_adv. It is combinational and does not depend on in_valid.
- Stage 1 register (s1_a, s1_b, s1_last, s1_valid):
  - Loads on transfer.
  - Clears s1_valid when s1_adv occurs without a new transfer.
- s1_adv = s1_valid && !(s1_last && out_valid && !out_ready). Only a completed vector whose output slot is still occupied stalls.
- Product: prod = mul(s1_a, s1_b).
  - The result is the low 16 bits of the product, i.e. a*b mod 2^16.
  - It is zero-extended to ACC_W+1 bits.
- State machine (states IDLE and ACCUM), on s1_adv:
  - IDLE: next = prod; cnt := 1; ovf := 0.
  - ACCUM: next = acc + prod; cnt := cnt+1, saturating at all-ones; ovf := ovf | carry out of bit ACC_W-1.
  - acc := next mod 2^ACC_W, i.e. the sum wraps.
  - If s1_last: load out_sum, out_count and out_ovf from the next-state values; set out_valid=1; clear acc, cnt and ovf; go to IDLE.
  - Otherwise go to ACCUM.
- Output register:
  - out_valid clears on out_valid && out_ready unless a new result loads on the same edge, in which case it stays 1 with the new data.
  - Data is stable while out_valid && !out_ready.
- Latency: a last pair accepted at edge k gives out_valid=1 after edge k+1.
- Throughput: 1 pair per clock when out_ready is held high.
- Empty vector: no output is produced.
- in_last on the first pair: out_sum = that product, out_count=1.
- No combinational path from in_* to out_*. The only combinational path from out_ready is to in_ready.

Test Plan:
- Basic dot product: pairs (3,4), (5,6), (7,8 last), out_ready=1 -> out_valid one cycle after the edge following the last acceptance; out_sum=98, out_count=3, out_ovf=0.
- Truncation: (0x0100,0x0100), (0xFFFF,0xFFFF last) -> products are 0x0000 and 0x0001; out_sum=1, out_count=2.
- Overflow with ACC_W=18: five pairs (0xFFFF,0x0001), last on the fifth -> out_sum=0x0FFFB, out_ovf=1, out_count=5. A following vector (2,3 last) -> out_sum=6, out_ovf=0.
- Back-pressure: out_ready=0; vector (1,1 last), then vector (2,2 last), then (4,4).
  - Result 1 is held.
  - The second last pair stalls in stage 1 with in_ready=0.
  - Raising out_ready gives results 1 then 4 on consecutive cycles, with no beat lost.
  - (4,4) starts the next vector.
- Reset mid-vector: (9,9), (9,9) accepted, then rst for 1 cycle, then (2,5 last) -> single result, out_sum=10, out_count=1.
- Streaming: 16 single-pair vectors (i,i), i=0..15, in_valid and out_ready held at 1 -> in_ready stays 1 and one result per cycle, out_sum=i*i.

Source files
------------

// File: rtl/mul_acc.sv
// Streaming multiply-accumulate around a 16x16 array multiplier: sums the truncated
// products of each in_last-delimited vector and emits sum, beat count and overflow flag.

module mul (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [31:0] o_p
);

    // w_row[r] holds the running partial sum shifted right by r; bit 0 is product bit r.
    logic [16:0] w_row [16];

    always_comb begin
        logic w_c;
        logic w_x;
        logic w_y;
        w_c = 1'b0;
        w_x = 1'b0;
        w_y = 1'b0;
        w_row[0] = {1'b0, i_a & {16{i_b[0]}}};
        for (int r = 1; r < 16; r++) begin
            w_c = 1'b0;
            for (int c = 0; c < 16; c++) begin
                w_x = w_row[r-1][c+1];
                w_y = i_a[c] & i_b[r];
                w_row[r][c] = w_x ^ w_y ^ w_c;
                w_c = (w_x & w_y) | (w_c & (w_x ^ w_y));
            end
            w_row[r][16] = w_c;
        end
        o_p = '0;
        for (int r = 0; r < 15; r++) begin
            o_p[r] = w_row[r][0];
        end
        o_p[31:15] = w_row[15];
    end

endmodule

module mul_acc #(
    parameter int unsigned ACC_W = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [15:0]      i_in_a,
    input  logic [15:0]      i_in_b,
    input  logic             i_in_last,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [ACC_W-1:0] o_out_sum,
    output logic [CNT_W-1:0] o_out_count,
    output logic             o_out_ovf
);

    typedef enum logic {StIdle, StAccum} state_e;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [15:0]      r_s1_a;
    logic [15:0]      r_s1_b;
    logic             r_s1_last;
    logic             r_s1_valid;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_acc_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_ovf;
    logic             w_ovf_nxt;
    logic             r_out_valid;
    logic [ACC_W-1:0] r_out_sum;
    logic [CNT_W-1:0] r_out_count;
    logic             r_out_ovf;

    logic             w_s1_adv;
    logic             w_xfer;
    logic             w_out_load;
    logic [31:0]      w_prod_full;
    logic [ACC_W:0]   w_prod_ext;
    logic [ACC_W:0]   w_sum_full;
    logic [CNT_W-1:0] w_cnt_calc;
    logic             w_ovf_calc;
    logic             w_unused_prod_hi;

    // Only a finished vector blocked by an occupied output slot holds stage 1.
    assign w_s1_adv   = r_s1_valid && !(r_s1_last && r_out_valid && !i_out_ready);
    assign o_in_ready = !r_s1_valid || w_s1_adv;
    assign w_xfer     = i_in_valid && o_in_ready;

    mul u_mul (
        .i_a (r_s1_a),
        .i_b (r_s1_b),
        .o_p (w_prod_full)
    );

    assign w_unused_prod_hi = ^w_prod_full[31:16];
    assign w_prod_ext       = {{(ACC_W-15){1'b0}}, w_prod_full[15:0]};

    always_comb begin
        w_sum_full = w_prod_ext;
        w_cnt_calc = CNT_W'(1);
        w_ovf_calc = 1'b0;
        if (r_state == StAccum) begin
            w_sum_full = {1'b0, r_acc} + w_prod_ext;
            w_cnt_calc = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
            w_ovf_calc = r_ovf | w_sum_full[ACC_W];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_ovf_nxt   = r_ovf;
        w_out_load  = 1'b0;
        if (w_s1_adv) begin
            if (r_s1_last) begin
                w_state_nxt = StIdle;
                w_acc_nxt   = '0;
                w_cnt_nxt   = '0;
                w_ovf_nxt   = 1'b0;
                w_out_load  = 1'b1;
            end else begin
                w_state_nxt = StAccum;
                w_acc_nxt   = w_sum_full[ACC_W-1:0];
                w_cnt_nxt   = w_cnt_calc;
                w_ovf_nxt   = w_ovf_calc;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_s1_a      <= '0;
            r_s1_b      <= '0;
            r_s1_last   <= 1'b0;
            r_s1_valid  <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_count <= '0;
            r_out_ovf   <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_s1_a     <= i_in_a;
                r_s1_b     <= i_in_b;
                r_s1_last  <= i_in_last;
                r_s1_valid <= 1'b1;
            end else if (w_s1_adv) begin
                r_s1_valid <= 1'b0;
            end
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ovf   <= w_ovf_nxt;
            if (w_out_load) begin
                r_out_valid <= 1'b1;
                r_out_sum   <= w_sum_full[ACC_W-1:0];
                r_out_count <= w_cnt_calc;
                r_out_ovf   <= w_ovf_calc;
            end else if (r_out_valid && i_out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_sum   = r_out_sum;
    assign o_out_count = r_out_count;
    assign o_out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_mul_acc.sv
// Directed bench for mul_acc: a 32-bit accumulator instance plus an 18-bit one sharing
// the same stimulus so wrap/overflow behaviour can be observed.

module tb_mul_acc;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic [15:0] out_count;
    logic        out_ovf;

    logic        in_ready18;
    logic        out_valid18;
    logic [17:0] out_sum18;
    logic [15:0] out_count18;
    logic        out_ovf18;

    int total = 0;
    int bad   = 0;

    mul_acc #(.ACC_W(32), .CNT_W(16)) u_dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_a      (in_a),
        .i_in_b      (in_b),
        .i_in_last   (in_last),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_sum   (out_sum),
        .o_out_count (out_count),
        .o_out_ovf   (out_ovf)
    );

    mul_acc #(.ACC_W(18), .CNT_W(16)) u_dut18 (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready18),
        .i_in_a      (in_a),
        .i_in_b      (in_b),
        .i_in_last   (in_last),
        .o_out_valid (out_valid18),
        .i_out_ready (out_ready),
        .o_out_sum   (out_sum18),
        .o_out_count (out_count18),
        .o_out_ovf   (out_ovf18)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed=still running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Presents one pair and holds it until accepted (bounded).
    task automatic push(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic last);
        int n;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        in_valid = 1'b1;
        #1;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            cyc();
            n++;
        end
        check({tag, "_ready"}, 64'(in_ready), 64'(1'b1));
        cyc();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_out(input string tag, input logic [31:0] sum, input logic [15:0] cnt,
                            input logic ovf);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            cyc();
            n++;
        end
        check({tag, "_valid"}, 64'(out_valid), 64'(1'b1));
        check({tag, "_sum"}, 64'(out_sum), 64'(sum));
        check({tag, "_count"}, 64'(out_count), 64'(cnt));
        check({tag, "_ovf"}, 64'(out_ovf), 64'(ovf));
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        check("rst_valid", 64'(out_valid), 64'(1'b0));
        check("rst_sum", 64'(out_sum), 64'(0));
        check("rst_count", 64'(out_count), 64'(0));
        check("rst_ovf", 64'(out_ovf), 64'(1'b0));
        check("rst_ready", 64'(in_ready), 64'(1'b1));

        // Basic dot product 3*4 + 5*6 + 7*8 = 98, with latency check.
        push("dot0", 16'd3, 16'd4, 1'b0);
        push("dot1", 16'd5, 16'd6, 1'b0);
        push("dot2", 16'd7, 16'd8, 1'b1);
        check("dot_lat_early", 64'(out_valid), 64'(1'b0));
        cyc();
        check("dot_lat_valid", 64'(out_valid), 64'(1'b1));
        wait_out("dot", 32'd98, 16'd3, 1'b0);
        cyc();
        check("dot_drained", 64'(out_valid), 64'(1'b0));

        // Truncation: 0x100*0x100 -> 0, 0xFFFF*0xFFFF -> 1.
        push("trn0", 16'h0100, 16'h0100, 1'b0);
        push("trn1", 16'hFFFF, 16'hFFFF, 1'b1);
        wait_out("trn", 32'd1, 16'd2, 1'b0);
        cyc();

        // Overflow: 5 * 0xFFFF = 0x4FFFB, wraps to 0x0FFFB in 18 bits.
        for (int i = 0; i < 5; i++) begin
            push("ovf_in", 16'hFFFF, 16'h0001, (i == 4));
        end
        wait_out("ovf32", 32'h0004FFFB, 16'd5, 1'b0);
        check("ovf18_valid", 64'(out_valid18), 64'(1'b1));
        check("ovf18_sum", 64'(out_sum18), 64'h0FFFB);
        check("ovf18_count", 64'(out_count18), 64'(5));
        check("ovf18_ovf", 64'(out_ovf18), 64'(1'b1));
        cyc();
        push("ovf_next", 16'd2, 16'd3, 1'b1);
        wait_out("ovf_next32", 32'd6, 16'd1, 1'b0);
        check("ovf18_next_sum", 64'(out_sum18), 64'(6));
        check("ovf18_next_ovf", 64'(out_ovf18), 64'(1'b0));
        cyc();

        // Back-pressure: result 1 held, second last pair stalls, then 1 and 4 back to back.
        out_ready = 1'b0;
        push("bp0", 16'd1, 16'd1, 1'b1);
        cyc();
        check("bp_r1_valid", 64'(out_valid), 64'(1'b1));
        push("bp1", 16'd2, 16'd2, 1'b1);
        in_a     = 16'd4;
        in_b     = 16'd4;
        in_last  = 1'b0;
        in_valid = 1'b1;
        #1;
        check("bp_stall_ready", 64'(in_ready), 64'(1'b0));
        cyc();
        check("bp_hold_sum", 64'(out_sum), 64'(1));
        check("bp_hold_valid", 64'(out_valid), 64'(1'b1));
        check("bp_hold_ready", 64'(in_ready), 64'(1'b0));
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 64'(in_ready), 64'(1'b1));
        check("bp_first_sum", 64'(out_sum), 64'(1));
        cyc();
        in_valid = 1'b0;
        check("bp_second_valid", 64'(out_valid), 64'(1'b1));
        check("bp_second_sum", 64'(out_sum), 64'(4));
        check("bp_second_count", 64'(out_count), 64'(1));
        cyc();
        check("bp_drained", 64'(out_valid), 64'(1'b0));
        push("bp2", 16'd1, 16'd3, 1'b1);
        wait_out("bp_next", 32'd19, 16'd2, 1'b0);
        cyc();

        // Reset mid-vector discards the partial sum.
        push("rm0", 16'd9, 16'd9, 1'b0);
        push("rm1", 16'd9, 16'd9, 1'b0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("rm_valid", 64'(out_valid), 64'(1'b0));
        check("rm_sum", 64'(out_sum), 64'(0));
        check("rm_ready", 64'(in_ready), 64'(1'b1));
        push("rm2", 16'd2, 16'd5, 1'b1);
        wait_out("rm", 32'd10, 16'd1, 1'b0);
        cyc();
        check("rm_single", 64'(out_valid), 64'(1'b0));
        cyc();

        // Streaming single-pair vectors at full rate.
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_a     = 16'(i);
            in_b     = 16'(i);
            in_last  = 1'b1;
            in_valid = 1'b1;
            #1;
            check("st_ready", 64'(in_ready), 64'(1'b1));
            if (i >= 2) begin
                check("st_valid", 64'(out_valid), 64'(1'b1));
                check("st_sum", 64'(out_sum), 64'((i - 2) * (i - 2)));
                check("st_count", 64'(out_count), 64'(1));
            end
            cyc();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        #1;
        check("st_sum14", 64'(out_sum), 64'(196));
        cyc();
        check("st_valid15", 64'(out_valid), 64'(1'b1));
        check("st_sum15", 64'(out_sum), 64'(225));
        cyc();
        check("st_drained", 64'(out_valid), 64'(1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
